// File: rtl/correlation_barker_arbiter_if.sv
// Bundles the per-channel source streams, the shared core ports and the tagged
// result stream of the correlation_barker arbiter. The master modport is the arbiter.
interface correlation_barker_arbiter_if #(
    parameter int NUM_CH = 4,
    parameter int CH_W   = $clog2(NUM_CH)
);
    logic [NUM_CH-1:0] s_tdata;
    logic [NUM_CH-1:0] s_tvalid;
    logic [NUM_CH-1:0] s_tlast;
    logic [NUM_CH-1:0] s_tready;

    logic              c_tdata;
    logic              c_tvalid;
    logic              c_tlast;
    logic              c_tready;
    logic              c_rtuser;
    logic              c_rtvalid;
    logic              c_rtready;

    logic              m_tuser;
    logic [CH_W-1:0]   m_tdest;
    logic              m_tvalid;
    logic              m_tready;

    logic [CH_W-1:0]   o_grant;
    logic              o_busy;
    logic              o_err;

    modport master (
        input  s_tdata, s_tvalid, s_tlast, c_tready, c_rtuser, c_rtvalid, m_tready,
        output s_tready, c_tdata, c_tvalid, c_tlast, c_rtready,
               m_tuser, m_tdest, m_tvalid, o_grant, o_busy, o_err
    );

    modport slave (
        output s_tdata, s_tvalid, s_tlast, c_tready, c_rtuser, c_rtvalid, m_tready,
        input  s_tready, c_tdata, c_tvalid, c_tlast, c_rtready,
               m_tuser, m_tdest, m_tvalid, o_grant, o_busy, o_err
    );
endinterface

// File: rtl/correlation_barker_arbiter.sv
// Packet-granular round-robin arbiter sharing one correlation_barker core between
// NUM_CH sources; every accepted beat is tagged so core results return with a tdest.
module correlation_barker_arbiter #(
    parameter int NUM_CH    = 4,
    parameter int TAG_DEPTH = 16,
    parameter int CH_W      = $clog2(NUM_CH)
) (
    input logic                        i_clk,
    input logic                        i_rst_n,
    correlation_barker_arbiter_if.master bus
);
    localparam int PTR_W = $clog2(TAG_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    state_t            state_q, state_d;
    logic [CH_W-1:0]   grant_q, grant_d;
    logic [CH_W-1:0]   rr_ptr_q, rr_ptr_d;
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic [CH_W-1:0]   tag_q [TAG_DEPTH];
    logic [CH_W-1:0]   tag_d [TAG_DEPTH];
    logic              err_q, err_d;

    logic              busy;
    logic              tag_full;
    logic              tag_empty;
    logic              push;
    logic              pop;
    logic              c_tvalid_w;
    logic              m_tvalid_w;
    logic [NUM_CH-1:0] s_tready_w;
    logic              found;
    logic [CH_W-1:0]   pick;
    logic [CH_W-1:0]   idx;

    always_comb begin
        busy       = (state_q == BUSY);
        tag_full   = (count_q == CNT_W'(TAG_DEPTH));
        tag_empty  = (count_q == '0);
        c_tvalid_w = busy & bus.s_tvalid[grant_q] & ~tag_full;
        s_tready_w = '0;
        if (busy) begin
            s_tready_w[grant_q] = bus.c_tready & ~tag_full;
        end
        push       = c_tvalid_w & bus.c_tready;
        m_tvalid_w = bus.c_rtvalid & ~tag_empty;
        pop        = m_tvalid_w & bus.m_tready;
    end

    assign bus.s_tready  = s_tready_w;
    assign bus.c_tvalid  = c_tvalid_w;
    assign bus.c_tdata   = busy & bus.s_tdata[grant_q];
    assign bus.c_tlast   = busy & bus.s_tlast[grant_q];
    assign bus.c_rtready = tag_empty | bus.m_tready;
    assign bus.m_tvalid  = m_tvalid_w;
    assign bus.m_tuser   = bus.c_rtuser;
    assign bus.m_tdest   = tag_q[rd_ptr_q];
    assign bus.o_grant   = grant_q;
    assign bus.o_busy    = busy;
    assign bus.o_err     = err_q;

    // First requester at or above rr_ptr, wrapping, wins the next packet.
    always_comb begin
        found = 1'b0;
        pick  = '0;
        idx   = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            idx = CH_W'((int'(rr_ptr_q) + i) % NUM_CH);
            if (!found && bus.s_tvalid[idx]) begin
                found = 1'b1;
                pick  = idx;
            end
        end
    end

    always_comb begin
        state_d  = state_q;
        grant_d  = grant_q;
        rr_ptr_d = rr_ptr_q;
        case (state_q)
            IDLE: begin
                if (found) begin
                    grant_d = pick;
                    state_d = BUSY;
                end
            end
            BUSY: begin
                if (push && bus.s_tlast[grant_q]) begin
                    state_d  = IDLE;
                    rr_ptr_d = (grant_q == CH_W'(NUM_CH - 1)) ? '0 : grant_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Pushes are already gated by tag_full, so the FIFO never overflows.
    always_comb begin
        wr_ptr_d = wr_ptr_q + PTR_W'(push);
        rd_ptr_d = rd_ptr_q + PTR_W'(pop);
        count_d  = count_q;
        case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
        tag_d = tag_q;
        if (push) begin
            tag_d[wr_ptr_q] = grant_q;
        end
        err_d = err_q | (bus.c_rtvalid & tag_empty);
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q  <= IDLE;
            grant_q  <= '0;
            rr_ptr_q <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            err_q    <= 1'b0;
            for (int i = 0; i < TAG_DEPTH; i++) begin
                tag_q[i] <= '0;
            end
        end else begin
            state_q  <= state_d;
            grant_q  <= grant_d;
            rr_ptr_q <= rr_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            err_q    <= err_d;
            tag_q    <= tag_d;
        end
    end
endmodule

// File: doc/correlation_barker_arbiter.md
# correlation_barker_arbiter

Packet-granular round-robin arbiter that shares one `correlation_barker` core between `NUM_CH` 1-bit AXI-Stream sources. It grants the core input to one channel for a whole packet, which ends on `tlast`. It also tags every accepted input beat with its channel index, so each core result beat comes back with a `tdest` naming its source. The block sits between the per-channel front ends and the core. The core's input and result ports connect directly to the `c_*` ports.

## Interface
Parameters:
- `NUM_CH`, default 4: number of requesting channels, 2..16.
- `TAG_DEPTH`, default 16: tag FIFO entries, a power of 2. Must be at least the core latency in beats plus 2.
- `CH_W`, default `$clog2(NUM_CH)`: width of the channel index.

Ports:
- `i_clk`  in  1  system clock.
- `i_rst_n`  in  1  asynchronous active-low reset.
- `s_tdata`  in  NUM_CH  per-channel data bit.
- `s_tvalid`  in  NUM_CH  per-channel valid.
- `s_tlast`  in  NUM_CH  per-channel end of packet.
- `s_tready`  out  NUM_CH  per-channel ready.
- `c_tdata`  out  1  data bit to the core.
- `c_tvalid`  out  1  valid to the core.
- `c_tlast`  out  1  end of packet to the core.
- `c_tready`  in  1  ready from the core.
- `c_rtuser`  in  1  core result flag.
- `c_rtvalid`  in  1  core result valid.
- `c_rtready`  out  1  ready to the core result port.
- `m_tuser`  out  1  result flag.
- `m_tdest`  out  CH_W  source channel of the result.
- `m_tvalid`  out  1  result valid.
- `m_tready`  in  1  result ready.
- `o_grant`  out  CH_W  currently or last granted channel.
- `o_busy`  out  1  high while a packet grant is held.
- `o_err`  out  1  sticky flag: a core result arrived with no tag.

## Operation
- The state machine has two states, IDLE and BUSY.
- IDLE:
  - If any `s_tvalid` is high, grant the first requester found by searching upward from `rr_ptr` with wrap-around.
  - Register the winner into `grant` and go to BUSY.
  - No beat is forwarded in IDLE.
- BUSY:
  - `c_tdata`, `c_tvalid` and `c_tlast` take the granted channel's inputs.
  - `c_tvalid = s_tvalid[grant] & !tag_full`.
  - `s_tready[grant] = c_tready & !tag_full`; every other `s_tready` is 0.
  - An input handshake (`c_tvalid & c_tready`) pushes `grant` into the tag FIFO.
  - A handshake with `c_tlast` high returns to IDLE and sets `rr_ptr = (grant+1) mod NUM_CH`.
- Tag FIFO:
  - Circular buffer with read and write pointers of `$clog2(TAG_DEPTH)` bits, wrapping naturally.
  - Occupancy count is `$clog2(TAG_DEPTH)+1` bits.
  - `tag_full` when count equals TAG_DEPTH; `tag_empty` when count is 0.
  - A push and a pop in the same cycle leave count unchanged.
  - A push while full cannot occur, because the input path is gated by `tag_full`.
- Result path:
  - `m_tvalid = c_rtvalid & !tag_empty`.
  - `m_tuser = c_rtuser`.
  - `m_tdest = tag[rd_ptr]`.
  - `c_rtready = tag_empty ? 1 : m_tready`.
  - A result handshake pops one tag.
- Error:
  - If `c_rtvalid` is high while the tag FIFO is empty, the beat is consumed and dropped and `o_err` is set.
  - `o_err` clears only on reset.
- Packet length is unbounded; a channel holds the grant until its `tlast` is accepted.
- A source that deasserts `tvalid` mid-packet stalls the core input and keeps the grant.

## Timing
- Reset (asynchronous, active-low) forces:
  - state to IDLE, `grant` to 0, `rr_ptr` to 0;
  - FIFO pointers and count to 0, `o_err` to 0;
  - all `s_tready` to 0, `c_tvalid` to 0, `m_tvalid` to 0;
  - `o_busy` to 0 and `o_grant` to 0.
- Reset mid-packet discards all tags. The core shares `i_rst_n` so that no orphan results follow.
- Arbitration latency: a request seen in IDLE at cycle N allows its first beat to be accepted at N+1 at the earliest.
- After a `tlast` handshake at cycle N, the next packet's first beat is accepted at N+2 at the earliest (one IDLE cycle).
- Within a packet the throughput is 1 beat per clock when the core and FIFO allow it.
- The input and result paths are combinational pass-through in BUSY; no register sits in the data path.
- `o_busy = (state == BUSY)`.
- `o_grant` is the registered `grant`.

## Test plan
1. Channels 0 and 2 each present a 13-beat packet at t0:
   - ch0 is granted first and ch2 second, with exactly one IDLE cycle between packets;
   - `s_tready[2]` stays 0 during ch0's packet.
2. All 4 channels request continuously with 3-beat packets:
   - grant order is 0,1,2,3,0,…;
   - each channel receives 25% of grants over 40 packets.
3. The core result port echoes after 5 cycles and `m_tready` is held 0, with TAG_DEPTH=8:
   - input stalls after 8 accepted beats (`s_tready=0`);
   - releasing `m_tready` resumes input;
   - `m_tdest` matches the source of every beat in order.
4. A result is injected on `c_rtvalid` with no input ever sent:
   - the beat is dropped (`m_tvalid=0`);
   - `o_err` rises the next cycle and stays high.
5. `i_rst_n` is pulsed low mid-packet on ch1 with 4 tags pending:
   - all outputs go to reset values immediately;
   - after release, ch1's new packet is granted and `m_tdest` tags start fresh.
6. A simultaneous push and pop at count=TAG_DEPTH-1 leaves the count unchanged, and neither full nor empty is asserted.
